// File: rtl/lpddr5_params.sv
// rtl/lpddr5_params.sv - LPDDR5 command/error encodings, geometry and timing set
package lpddr5_params;

  localparam int BANK_NUMBER                      = 16;
  localparam int ROW_PER_BANK_GROUP_ADDRESS_WIDTH = 16;
  localparam int COL_WIDTH                        = 6;
  localparam int DATA_WIDTH                       = 32;

  // Timing set in clock cycles
  localparam int T_RCD  = 4;
  localparam int T_RP   = 4;
  localparam int T_RAS  = 10;
  localparam int T_RC   = 14;
  localparam int T_WR   = 4;
  localparam int T_RFC  = 20;
  localparam int T_REFI = 100;
  localparam int T_CL   = 4;

  localparam int CNT_W     = 5;
  localparam int REF_AGE_W = 8;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } lpddr5_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_ACT  = 3'd1,
    ERR_RD   = 3'd2,
    ERR_WR   = 3'd3,
    ERR_PRE  = 3'd4,
    ERR_REF  = 3'd5,
    ERR_BUSY = 3'd6
  } lpddr5_err_e;

  // A counter loaded with t-1 reaches zero exactly t cycles after the load
  function automatic logic [CNT_W-1:0] t_load(input int t);
    return CNT_W'(t - 1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] x);
    return (x == '0) ? x : x - 1'b1;
  endfunction

endpackage

// File: rtl/lpddr5_bank_timer.sv
// rtl/lpddr5_bank_timer.sv - one bank's open state, open row and timing counters
module lpddr5_bank_timer
  import lpddr5_params::*;
#(
  parameter int ROW_W = ROW_PER_BANK_GROUP_ADDRESS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic             wr,
  input  logic             pre,
  input  logic [ROW_W-1:0] row,
  output logic             bank_open,
  output logic [ROW_W-1:0] open_row,
  output logic             act_ok,
  output logic             rw_ok,
  output logic             pre_ok,
  output logic             rp_idle
);

  logic [CNT_W-1:0] cnt_rcd, cnt_ras, cnt_rc, cnt_rp, cnt_wr;

  // Strobes arrive only for commands already judged legal
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open <= 1'b0;
      open_row  <= '0;
      cnt_rcd   <= '0;
      cnt_ras   <= '0;
      cnt_rc    <= '0;
      cnt_rp    <= '0;
      cnt_wr    <= '0;
    end else begin
      cnt_rcd <= act ? t_load(T_RCD) : sat_dec(cnt_rcd);
      cnt_ras <= act ? t_load(T_RAS) : sat_dec(cnt_ras);
      cnt_rc  <= act ? t_load(T_RC)  : sat_dec(cnt_rc);
      cnt_rp  <= pre ? t_load(T_RP)  : sat_dec(cnt_rp);
      cnt_wr  <= wr  ? t_load(T_WR)  : sat_dec(cnt_wr);
      if (act) begin
        bank_open <= 1'b1;
        open_row  <= row;
      end else if (pre) begin
        bank_open <= 1'b0;
      end
    end
  end

  assign act_ok  = !bank_open && (cnt_rp == '0) && (cnt_rc == '0);
  assign rw_ok   = bank_open && (cnt_rcd == '0);
  // PRE to a closed bank is always acceptable
  assign pre_ok  = !bank_open || ((cnt_ras == '0) && (cnt_wr == '0));
  assign rp_idle = (cnt_rp == '0);

endmodule

// File: rtl/lpddr5_device_responder.sv
// rtl/lpddr5_device_responder.sv - LPDDR5 device-side responder and protocol checker
module lpddr5_device_responder
  import lpddr5_params::*;
#(
  parameter int BANKS = BANK_NUMBER,
  parameter int ROW_W = ROW_PER_BANK_GROUP_ADDRESS_WIDTH,
  parameter int COL_W = COL_WIDTH,
  parameter int DW    = DATA_WIDTH,
  localparam int BW   = $clog2(BANKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [BW-1:0]    cmd_bank,
  input  logic [ROW_W-1:0] cmd_row,
  input  logic [COL_W-1:0] cmd_col,
  output logic             rd_valid,
  output logic [DW-1:0]    rd_data,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic             ref_overdue
);

  logic [BANKS-1:0] act_ok, rw_ok, pre_ok, rp_idle, bank_open;
  logic [BANKS-1:0] act_go, wr_go, pre_go;
  logic [ROW_W-1:0] open_row [BANKS];

  logic [CNT_W-1:0]     cnt_rfc;
  logic [REF_AGE_W-1:0] ref_age;
  lpddr5_cmd_e          op;
  lpddr5_err_e          err;
  logic                 is_cmd, go, rd_go, ref_go;

  assign op     = lpddr5_cmd_e'(cmd);
  assign is_cmd = op inside {ACT, RD, WR, PRE, REF};

  // Refresh busy outranks every per-command check
  always_comb begin
    err = ERR_NONE;
    if (cmd_valid && is_cmd) begin
      case (op)
        ACT:     if (!act_ok[cmd_bank]) err = ERR_ACT;
        RD:      if (!rw_ok[cmd_bank])  err = ERR_RD;
        WR:      if (!rw_ok[cmd_bank])  err = ERR_WR;
        PRE:     if (!pre_ok[cmd_bank]) err = ERR_PRE;
        REF:     if ((|bank_open) || !(&rp_idle)) err = ERR_REF;
        default: err = ERR_NONE;
      endcase
      if (cnt_rfc != '0) err = ERR_BUSY;
    end
  end

  assign go     = cmd_valid && is_cmd && (err == ERR_NONE);
  assign rd_go  = go && (op == RD);
  assign ref_go = go && (op == REF);

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic sel;
    assign sel       = (cmd_bank == BW'(b));
    assign act_go[b] = go && sel && (op == ACT);
    assign wr_go[b]  = go && sel && (op == WR);
    assign pre_go[b] = go && sel && (op == PRE) && bank_open[b];

    lpddr5_bank_timer #(.ROW_W(ROW_W)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .act       (act_go[b]),
      .wr        (wr_go[b]),
      .pre       (pre_go[b]),
      .row       (cmd_row),
      .bank_open (bank_open[b]),
      .open_row  (open_row[b]),
      .act_ok    (act_ok[b]),
      .rw_ok     (rw_ok[b]),
      .pre_ok    (pre_ok[b]),
      .rp_idle   (rp_idle[b])
    );
  end

  // Read pipe: data stages only advance with a valid token, so the tail holds
  logic [T_CL-1:0] pipe_v;
  logic [DW-1:0]   pipe_d [T_CL];
  logic [DW-1:0]   rd_word;

  assign rd_word = DW'({open_row[cmd_bank], cmd_bank, cmd_col});

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < T_CL; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v <= {pipe_v[T_CL-2:0], rd_go};
      if (rd_go) pipe_d[0] <= rd_word;
      for (int i = 1; i < T_CL; i++) begin
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign rd_valid = pipe_v[T_CL-1];
  assign rd_data  = pipe_d[T_CL-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      cnt_rfc   <= '0;
      ref_age   <= '0;
    end else begin
      err_valid <= (err != ERR_NONE);
      if (err != ERR_NONE) err_code <= err;
      cnt_rfc <= ref_go ? t_load(T_RFC) : sat_dec(cnt_rfc);
      if (ref_go)        ref_age <= '0;
      else if (~&ref_age) ref_age <= ref_age + 1'b1;
    end
  end

  assign ref_overdue = (ref_age > REF_AGE_W'(T_REFI));

endmodule

// File: tb/tb_lpddr5_device_responder.sv
// tb/tb_lpddr5_device_responder.sv - scoreboard bench with a timestamp-based protocol model
module tb_lpddr5_device_responder;

  localparam int TRCD = 4, TRP = 4, TRAS = 10, TRC = 14, TWR = 4, TRFC = 20, TREFI = 100, CL = 4;
  localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4, C_REF = 5;
  localparam int NEVER = -1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [3:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [5:0]  cmd_col;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err_valid;
  logic [2:0]  err_code;
  logic        ref_overdue;

  lpddr5_device_responder dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_bank    (cmd_bank),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .ref_overdue (ref_overdue)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] data; } rd_exp_t;
  typedef struct { int due; int code; } err_exp_t;
  rd_exp_t  rq[$];
  err_exp_t eq[$];

  int tests = 0;
  int fails = 0;

  // Model: absolute timestamps of the last command of each kind per bank
  bit open_m [16];
  int row_m [16];
  int last_act [16];
  int last_pre [16];
  int last_wr [16];
  int last_ref;
  int age_base = 0;
  int new_base = 0;
  logic [31:0] hold_rd = '0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard queues
  bit m_exp_rd, m_exp_err;
  rd_exp_t m_rd;
  err_exp_t m_err;
  always @(negedge clk) begin
    if (mon_en) begin
      if (new_base <= cyc) age_base = new_base;
      m_exp_rd = (rq.size() > 0) && (rq[0].due == cyc);
      check("rd_valid", rd_valid, m_exp_rd);
      if (m_exp_rd) begin
        m_rd = rq.pop_front();
        check("rd_data", rd_data, m_rd.data);
        hold_rd = m_rd.data;
      end else begin
        check("rd_data_hold", rd_data, hold_rd);
      end
      m_exp_err = (eq.size() > 0) && (eq[0].due == cyc);
      check("err_valid", err_valid, m_exp_err);
      if (m_exp_err) begin
        m_err = eq.pop_front();
        check("err_code", err_code, m_err.code);
      end
      check("ref_overdue", ref_overdue, (cyc - age_base) > TREFI);
    end
  end

  task automatic model_clear();
    for (int k = 0; k < 16; k++) begin
      open_m[k] = 0; row_m[k] = 0;
      last_act[k] = NEVER; last_pre[k] = NEVER; last_wr[k] = NEVER;
    end
    last_ref = NEVER;
  endtask

  task automatic issue(input int c, input int b, input int r, input int col, input bit v = 1'b1);
    int n, code;
    n = cyc;
    cmd_valid = v; cmd = c[2:0]; cmd_bank = b[3:0]; cmd_row = r[15:0]; cmd_col = col[5:0];
    code = 0;
    if (v && c >= C_ACT && c <= C_REF) begin
      if (n < last_ref + TRFC) code = 6;
      else begin
        case (c)
          C_ACT: if (open_m[b] || n < last_pre[b] + TRP || n < last_act[b] + TRC) code = 1;
          C_RD, C_WR: if (!open_m[b] || n < last_act[b] + TRCD) code = c;
          C_PRE: if (open_m[b] && (n < last_act[b] + TRAS || n < last_wr[b] + TWR)) code = 4;
          default: for (int k = 0; k < 16; k++) if (open_m[k] || n < last_pre[k] + TRP) code = 5;
        endcase
      end
      if (code != 0) eq.push_back('{n + 1, code});
      else begin
        case (c)
          C_ACT: begin open_m[b] = 1; row_m[b] = r & 16'hffff; last_act[b] = n; end
          C_RD: rq.push_back('{n + CL, 32'(row_m[b] * 1024 + b * 64 + (col & 63))});
          C_WR: last_wr[b] = n;
          C_PRE: if (open_m[b]) begin open_m[b] = 0; last_pre[b] = n; end
          default: begin last_ref = n; new_base = n + 1; end
        endcase
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    repeat (k) issue(C_NOP, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    int r;
    rd_exp_t keep[$];
    r = cyc;
    rst = 1'b1; cmd_valid = 1'b0; cmd = 3'd0;
    foreach (rq[i]) if (rq[i].due <= r) keep.push_back(rq[i]);
    rq = keep;
    model_clear();
    @(posedge clk); #1;
    new_base = r + 1; hold_rd = '0;
    @(posedge clk); #1;
    new_base = r + 2;
    rst = 1'b0;
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_err_valid", err_valid, 0);
    check("reset_err_code", err_code, 0);
    check("reset_ref_overdue", ref_overdue, 0);
  endtask

  int sel;
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; cmd_bank = 4'd0; cmd_row = 16'd0; cmd_col = 6'd0;
    do_reset();
    mon_en = 1'b1;

    // Refresh age from reset, then a legal REF clears it
    idle(105);
    issue(C_REF, 0, 0, 0);
    idle(25);

    // ACT/RD latency and data, then an early RD
    issue(C_ACT, 3, 16'h1234, 0); idle(3); issue(C_RD, 3, 0, 5); idle(6);
    issue(C_ACT, 0, 16'h00aa, 0); idle(2); issue(C_RD, 0, 0, 1); idle(8);

    // tRAS then tRP window on bank 1
    issue(C_ACT, 1, 16'hbeef, 0); idle(8);
    issue(C_PRE, 1, 0, 0); issue(C_PRE, 1, 0, 0); idle(2);
    issue(C_ACT, 1, 16'h0001, 0); issue(C_ACT, 1, 16'h0002, 0);

    // tWR window on bank 2
    issue(C_ACT, 2, 16'h0222, 0); idle(19);
    issue(C_WR, 2, 0, 7); idle(2);
    issue(C_PRE, 2, 0, 0); issue(C_PRE, 2, 0, 0);

    // REF with an open bank, then tRFC busy window
    issue(C_ACT, 5, 16'h0555, 0); idle(5);
    issue(C_REF, 0, 0, 0); idle(12);
    for (int b = 0; b < 16; b++) issue(C_PRE, b, 0, 0);
    idle(3);
    issue(C_REF, 0, 0, 0); idle(18);
    issue(C_ACT, 4, 16'h0444, 0); issue(C_ACT, 4, 16'h0444, 0);
    idle(5); issue(C_RD, 4, 0, 63); issue(C_RD, 4, 0, 62); idle(6);

    // Reset two cycles after a read drops it
    issue(C_ACT, 7, 16'h7777, 0); idle(3); issue(C_RD, 7, 0, 3); idle(1);
    do_reset();
    idle(10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 99);
      if ($urandom_range(0, 599) == 0) do_reset();
      else if (sel < 95)
        issue(sel < 25 ? C_ACT : sel < 45 ? C_RD : sel < 60 ? C_WR : sel < 82 ? C_PRE :
              sel < 85 ? C_REF : C_NOP,
              ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(0, 15),
              $urandom_range(0, 65535), $urandom_range(0, 63));
      else
        issue($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 65535),
              $urandom_range(0, 63), 1'b0);
    end
    idle(CL + 4);
    check("rd_queue_drained", rq.size(), 0);
    check("err_queue_drained", eq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
